key_event_debounce: RTL and testbench
=====================================

# key_event_debounce

Multi-key debounce and event generator: for each of WIDTH keys it synchronises the raw input and debounces it. It then emits single-cycle press, release, long-press and auto-repeat pulses. Each key has its own polarity and its own repeat enable. It sits between the board push-buttons and the countdown control FSM, so the controller sees clean, per-key events for short press, hold-to-set and fast-scroll entry.

## Interface
- WIDTH, 4, number of independent keys
- CNT_MAX, 20_000, debounce window in clk cycles; a level change commits after CNT_MAX+1 consecutive mismatching samples (2 ms at 10 MHz)
- LONG_MAX, 10_000_000, clk cycles from press_pulse to long_pulse (1 s at 10 MHz)
- REP_MAX, 2_000_000, clk cycles between auto-repeat pulses (200 ms at 10 MHz)
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- key_in  in  WIDTH  raw asynchronous key inputs
- active_hi  in  WIDTH  per-key polarity, quasi-static: 1 = key pressed when high, 0 = pressed when low
- rep_en  in  WIDTH  per-key auto-repeat enable, quasi-static
- pressed  out  WIDTH  debounced state, 1 = pressed, polarity-normalised
- press_pulse  out  WIDTH  one-cycle pulse on debounced press
- release_pulse  out  WIDTH  one-cycle pulse on debounced release
- long_pulse  out  WIDTH  one-cycle pulse when a hold reaches LONG_MAX
- repeat_pulse  out  WIDTH  one-cycle pulse every REP_MAX cycles while held past long-press with rep_en=1
- any_event  out  1  registered OR of all four pulse vectors from the same cycle

## Operation
Inputs and synchronisation
- Polarity is normalised before synchronisation: n[i] = key_in[i] XNOR active_hi[i].
- n passes through a 2-FF synchroniser, giving s[i].

Debounce, per key
- While s[i] != pressed[i], the counter increments.
- When s[i] != pressed[i] and the counter == CNT_MAX, pressed[i] toggles and the counter clears.
- Any cycle with s[i] == pressed[i] clears the counter. A glitch of ≤ CNT_MAX cycles therefore produces nothing.

Per-key FSM with states IDLE, HOLD and LONG
- IDLE → HOLD on press commit. press_pulse fires and the hold counter clears.
- In HOLD, the hold counter increments every cycle. When it reaches LONG_MAX-1, long_pulse fires, the FSM goes to LONG and the repeat counter clears.
- In LONG with rep_en=1, the repeat counter increments. When it reaches REP_MAX-1, repeat_pulse fires and the counter clears.
- In LONG with rep_en=0, the repeat counter holds at 0.
- HOLD or LONG → IDLE on release commit. release_pulse fires and all counters clear.

Boundary rules
- Release commit in the same cycle as a long or repeat terminal count: release wins, and no long_pulse or repeat_pulse is issued.
- rep_en deasserted mid-LONG: the repeat counter clears. Re-asserting it restarts the full REP_MAX interval.
- Counter widths are $clog2(MAX+1) bits. No counter may wrap; each counter saturates or clears at its terminal value.
- Legal parameter ranges are CNT_MAX ≥ 1, LONG_MAX ≥ 2 and REP_MAX ≥ 1. Violating them is an elaboration error.

Reset
- All outputs are 0 after reset.
- Synchroniser and pressed are cleared to "released", the FSM is IDLE and all counters are 0.
- A key held through reset is reported as a fresh press after the debounce window.
- Reset asserted mid-hold aborts the hold. No release_pulse is emitted.

## Timing
- Press latency: a change on key_in set up before edge E gives pressed and press_pulse high in the cycle after edge E+CNT_MAX+2.
- Release latency is identical.
- long_pulse is high exactly LONG_MAX cycles after press_pulse.
- The first repeat_pulse comes REP_MAX cycles after long_pulse; later ones follow every REP_MAX cycles.
- All pulses last exactly 1 cycle.
- any_event lags the pulses by 1 cycle.
- Keys are fully independent, so simultaneous events on different keys are all reported in the same cycle.

## Structure
- Package key_event_pkg holds:
  - typedef enum for the FSM states (IDLE, HOLD, LONG)
  - a constant function returning counter width
  - polarity encoding constants
- Sub-module key_event_channel holds a single key's synchroniser, debounce counter, FSM and hold/repeat counters.
- The top generate-loops WIDTH channel instances and registers any_event.

## Test plan
Bench parameters: WIDTH=4, CNT_MAX=3, LONG_MAX=20, REP_MAX=5.
- Clean press: drive key0 high (active_hi=1) before edge 10 → press_pulse[0] in the cycle after edge 15, and pressed[0]=1 from then on.
- Bounce: drive key1 high for 3 cycles, low for 2, then high steady → no pulse during the bounce, and exactly one press_pulse[1] 6 cycles after the final rise.
- Long and repeat: hold key2 with rep_en[2]=1 → long_pulse 20 cycles after press_pulse, then repeat_pulse at +25, +30 and +35. On release, exactly one release_pulse and no further repeats.
- Active-low and no repeat: key3 with active_hi=0 and rep_en=0, driven low and held for 40 cycles → press_pulse, long_pulse at +20, zero repeat_pulse. Driving high again gives release_pulse.
- Reset mid-hold: assert rst for 1 cycle while key0 is in LONG → all outputs 0 on the next cycle with no release_pulse. Because key0 is still held, press_pulse reappears 6 cycles after rst deasserts.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared types and helpers for the per-key debounce / event generator.
package key_event_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_LONG = 2'd2
   } key_state_e;

   localparam logic POL_ACTIVE_LOW  = 1'b0;
   localparam logic POL_ACTIVE_HIGH = 1'b1;

   // Bits needed to hold values 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/key_event_channel.sv
// One key: polarity normalise, 2-FF synchroniser, debounce counter and the
// IDLE/HOLD/LONG event FSM with its hold and repeat counters.
module key_event_channel
   import key_event_pkg::*;
#(
   parameter int CNT_MAX  = 20_000,
   parameter int LONG_MAX = 10_000_000,
   parameter int REP_MAX  = 2_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_i,
   input  logic active_hi_i,
   input  logic rep_en_i,
   output logic pressed_o,
   output logic press_pulse_o,
   output logic release_pulse_o,
   output logic long_pulse_o,
   output logic repeat_pulse_o
);

   localparam int DW = cnt_width(CNT_MAX);
   localparam int HW = cnt_width(LONG_MAX);
   localparam int RW = cnt_width(REP_MAX);

   localparam logic [DW-1:0] DB_TERM   = DW'(CNT_MAX);
   localparam logic [HW-1:0] HOLD_TERM = HW'(LONG_MAX - 1);
   localparam logic [RW-1:0] REP_TERM  = RW'(REP_MAX - 1);

   logic            sync1_q, sync2_q;
   logic            pressed_q;
   logic [DW-1:0]   db_cnt_q;
   logic [HW-1:0]   hold_cnt_q;
   logic [RW-1:0]   rep_cnt_q;
   key_state_e      state_q;
   logic            press_q, release_q, long_q, repeat_q;

   logic            norm_key_d;
   logic            mismatch_d;
   logic            commit_d;

   assign norm_key_d = (active_hi_i == POL_ACTIVE_HIGH) ? key_i : ~key_i;
   assign mismatch_d = (sync2_q != pressed_q);
   assign commit_d   = mismatch_d && (db_cnt_q == DB_TERM);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         pressed_q  <= 1'b0;
         db_cnt_q   <= '0;
         hold_cnt_q <= '0;
         rep_cnt_q  <= '0;
         state_q    <= ST_IDLE;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
         repeat_q   <= 1'b0;
      end else begin
         sync1_q   <= norm_key_d;
         sync2_q   <= sync1_q;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;

         if (!mismatch_d) begin
            db_cnt_q <= '0;
         end else if (commit_d) begin
            db_cnt_q  <= '0;
            pressed_q <= ~pressed_q;
         end else begin
            db_cnt_q <= db_cnt_q + DW'(1);
         end

         // A release commit is checked first so it pre-empts a coincident long/repeat.
         case (state_q)
            ST_IDLE: begin
               if (commit_d) begin
                  state_q    <= ST_HOLD;
                  press_q    <= 1'b1;
                  hold_cnt_q <= '0;
                  rep_cnt_q  <= '0;
               end
            end
            ST_HOLD: begin
               if (commit_d) begin
                  state_q    <= ST_IDLE;
                  release_q  <= 1'b1;
                  hold_cnt_q <= '0;
                  rep_cnt_q  <= '0;
               end else if (hold_cnt_q == HOLD_TERM) begin
                  state_q   <= ST_LONG;
                  long_q    <= 1'b1;
                  rep_cnt_q <= '0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HW'(1);
               end
            end
            ST_LONG: begin
               if (commit_d) begin
                  state_q    <= ST_IDLE;
                  release_q  <= 1'b1;
                  hold_cnt_q <= '0;
                  rep_cnt_q  <= '0;
               end else if (!rep_en_i) begin
                  rep_cnt_q <= '0;
               end else if (rep_cnt_q == REP_TERM) begin
                  repeat_q  <= 1'b1;
                  rep_cnt_q <= '0;
               end else begin
                  rep_cnt_q <= rep_cnt_q + RW'(1);
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               hold_cnt_q <= '0;
               rep_cnt_q  <= '0;
            end
         endcase
      end
   end

   assign pressed_o       = pressed_q;
   assign press_pulse_o   = press_q;
   assign release_pulse_o = release_q;
   assign long_pulse_o    = long_q;
   assign repeat_pulse_o  = repeat_q;

endmodule

// File: rtl/key_event_debounce.sv
// Multi-key debounce and event generator: one channel per key plus a
// registered any_event summary of all pulses.
module key_event_debounce
   import key_event_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int CNT_MAX  = 20_000,
   parameter int LONG_MAX = 10_000_000,
   parameter int REP_MAX  = 2_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] key_in,
   input  logic [WIDTH-1:0] active_hi,
   input  logic [WIDTH-1:0] rep_en,
   output logic [WIDTH-1:0] pressed,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] release_pulse,
   output logic [WIDTH-1:0] long_pulse,
   output logic [WIDTH-1:0] repeat_pulse,
   output logic             any_event
);

   if (CNT_MAX < 1) begin : g_bad_cnt_max
      $error("key_event_debounce: CNT_MAX must be >= 1");
   end
   if (LONG_MAX < 2) begin : g_bad_long_max
      $error("key_event_debounce: LONG_MAX must be >= 2");
   end
   if (REP_MAX < 1) begin : g_bad_rep_max
      $error("key_event_debounce: REP_MAX must be >= 1");
   end

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_key
         key_event_channel #(
            .CNT_MAX  (CNT_MAX),
            .LONG_MAX (LONG_MAX),
            .REP_MAX  (REP_MAX)
         ) u_channel (
            .clk             (clk),
            .rst             (rst),
            .key_i           (key_in[gi]),
            .active_hi_i     (active_hi[gi]),
            .rep_en_i        (rep_en[gi]),
            .pressed_o       (pressed[gi]),
            .press_pulse_o   (press_pulse[gi]),
            .release_pulse_o (release_pulse[gi]),
            .long_pulse_o    (long_pulse[gi]),
            .repeat_pulse_o  (repeat_pulse[gi])
         );
      end
   endgenerate

   logic any_event_d;
   logic any_event_q;

   assign any_event_d = |{press_pulse, release_pulse, long_pulse, repeat_pulse};

   always_ff @(posedge clk) begin
      if (rst) begin
         any_event_q <= 1'b0;
      end else begin
         any_event_q <= any_event_d;
      end
   end

   assign any_event = any_event_q;

endmodule

// File: tb/tb_key_event_debounce.sv
// Scoreboard bench: the stimulus timeline queues expected pulses by cycle,
// a negedge monitor pops and compares every pulse vector and any_event.
module tb_key_event_debounce;
   import key_event_pkg::*;

   localparam int WIDTH    = 4;
   localparam int CNT_MAX  = 3;
   localparam int LONG_MAX = 20;
   localparam int REP_MAX  = 5;

   localparam int K_PRESS   = 0;
   localparam int K_RELEASE = 1;
   localparam int K_LONG    = 2;
   localparam int K_REPEAT  = 3;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] key_in;
   logic [WIDTH-1:0] active_hi;
   logic [WIDTH-1:0] rep_en;
   logic [WIDTH-1:0] pressed;
   logic [WIDTH-1:0] press_pulse;
   logic [WIDTH-1:0] release_pulse;
   logic [WIDTH-1:0] long_pulse;
   logic [WIDTH-1:0] repeat_pulse;
   logic             any_event;

   typedef struct {
      int cyc;
      int key;
      int kind;
   } ev_t;

   ev_t sb_q[$];
   bit  any_exp[int];
   int  cyc;
   int  checks;
   int  failures;

   key_event_debounce #(
      .WIDTH    (WIDTH),
      .CNT_MAX  (CNT_MAX),
      .LONG_MAX (LONG_MAX),
      .REP_MAX  (REP_MAX)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .key_in        (key_in),
      .active_hi     (active_hi),
      .rep_en        (rep_en),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse),
      .any_event     (any_event)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // cyc == N at the negedge that follows the N-th rising edge.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_ev(input int kind, input int key, input int c);
      ev_t e;
      e.cyc  = c;
      e.key  = key;
      e.kind = kind;
      sb_q.push_back(e);
      any_exp[c + 1] = 1'b1;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check_pressed(input int c, input logic [WIDTH-1:0] req);
      wait_cyc(c);
      checks++;
      if (pressed !== req) begin
         failures++;
         $display("FAIL pressed cyc=%0d actual=%b required=%b", cyc, pressed, req);
      end
   endtask

   task automatic cmp_vec(input string name, input logic [WIDTH-1:0] act,
                          input logic [WIDTH-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
      end else if (req != '0) begin
         $display("ok   %s cyc=%0d value=%b", name, cyc, act);
      end
   endtask

   always @(negedge clk) begin
      if (cyc >= 1) begin
         logic [WIDTH-1:0] exp_v[4];
         logic             exp_any;
         for (int k = 0; k < 4; k++) exp_v[k] = '0;
         for (int i = 0; i < sb_q.size(); ) begin
            if (sb_q[i].cyc == cyc) begin
               exp_v[sb_q[i].kind][sb_q[i].key] = 1'b1;
               sb_q.delete(i);
            end else begin
               i++;
            end
         end
         exp_any = any_exp.exists(cyc);
         cmp_vec("press_pulse",   press_pulse,   exp_v[K_PRESS]);
         cmp_vec("release_pulse", release_pulse, exp_v[K_RELEASE]);
         cmp_vec("long_pulse",    long_pulse,    exp_v[K_LONG]);
         cmp_vec("repeat_pulse",  repeat_pulse,  exp_v[K_REPEAT]);
         checks++;
         if (any_event !== exp_any) begin
            failures++;
            $display("FAIL any_event cyc=%0d actual=%b required=%b", cyc, any_event, exp_any);
         end
      end
   end

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      key_in    = 4'b1000;
      active_hi = {POL_ACTIVE_LOW, POL_ACTIVE_HIGH, POL_ACTIVE_HIGH, POL_ACTIVE_HIGH};
      rep_en    = 4'b0100;

      check_pressed(1, 4'b0000);
      wait_cyc(2);
      rst = 1'b0;

      // Clean press on key0, set up before edge 10.
      wait_cyc(9);
      key_in[0] = 1'b1;
      expect_ev(K_PRESS, 0, 15);
      expect_ev(K_LONG,  0, 35);
      check_pressed(14, 4'b0000);
      check_pressed(15, 4'b0001);

      // Bounce on key1: 3 high, 2 low, then steady high.
      wait_cyc(20);
      key_in[1] = 1'b1;
      wait_cyc(23);
      key_in[1] = 1'b0;
      wait_cyc(25);
      key_in[1] = 1'b1;
      expect_ev(K_PRESS, 1, 31);
      expect_ev(K_LONG,  1, 51);
      check_pressed(30, 4'b0001);
      check_pressed(31, 4'b0011);
      wait_cyc(60);
      key_in[1] = 1'b0;
      expect_ev(K_RELEASE, 1, 66);
      check_pressed(65, 4'b0011);
      check_pressed(66, 4'b0001);

      // Long and repeat on key2; release commit lands on a repeat terminal count.
      wait_cyc(70);
      key_in[2] = 1'b1;
      expect_ev(K_PRESS,  2, 76);
      expect_ev(K_LONG,   2, 96);
      expect_ev(K_REPEAT, 2, 101);
      expect_ev(K_REPEAT, 2, 106);
      expect_ev(K_REPEAT, 2, 111);
      wait_cyc(110);
      key_in[2] = 1'b0;
      expect_ev(K_RELEASE, 2, 116);
      check_pressed(115, 4'b0101);
      check_pressed(116, 4'b0001);

      // Active-low key3 with repeat disabled, held 40 cycles.
      wait_cyc(130);
      key_in[3] = 1'b0;
      expect_ev(K_PRESS, 3, 136);
      expect_ev(K_LONG,  3, 156);
      wait_cyc(170);
      key_in[3] = 1'b1;
      expect_ev(K_RELEASE, 3, 176);
      check_pressed(175, 4'b1001);
      check_pressed(176, 4'b0001);

      // One-cycle reset while key0 sits in LONG: no release, fresh press later.
      wait_cyc(190);
      rst = 1'b1;
      check_pressed(191, 4'b0000);
      rst = 1'b0;
      expect_ev(K_PRESS, 0, 197);
      expect_ev(K_LONG,  0, 217);
      check_pressed(196, 4'b0000);
      check_pressed(197, 4'b0001);

      wait_cyc(230);
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
